// File: rtl/control_unit.sv
// control_unit
//   Main decoder + ALU decoder for the single-cycle MIPS-subset core.
//   The instruction word is decoded combinationally and every output is
//   captured in a flop, so the outputs lag iw by exactly one rising edge
//   and nothing on iw between edges can reach the outputs.
//
// Ports
//   clk       system clock, outputs update on rising edge
//   rst_n     asynchronous active-low reset, forces all outputs to 0
//   iw        32-bit instruction word (opcode iw[31:26], funct iw[5:0])
//   ALUCtrl   4-bit ALU operation code
//   ALUOp     2-bit ALU class from main decode (00 add, 01 sub, 10 funct)
//   regDst    1 = destination rd, 0 = destination rt
//   regWrite  register-file write enable
//   ALUSrc    1 = ALU B operand is the sign-extended immediate
//   memWrite  data-memory write enable
//   memRead   data-memory read enable
//   memToReg  1 = writeback from memory
//   branch    beq request
//   illegal   instruction outside the supported set
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] iw,
  output logic [3:0]  ALUCtrl,
  output logic [1:0]  ALUOp,
  output logic        regDst,
  output logic        regWrite,
  output logic        ALUSrc,
  output logic        memWrite,
  output logic        memRead,
  output logic        memToReg,
  output logic        branch,
  output logic        illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;

  localparam logic [3:0] AC_AND = 4'b0000;
  localparam logic [3:0] AC_OR  = 4'b0001;
  localparam logic [3:0] AC_ADD = 4'b0010;
  localparam logic [3:0] AC_SUB = 4'b0110;
  localparam logic [3:0] AC_SLT = 4'b0111;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  logic [5:0] opcode;
  logic [5:0] funct;
  assign opcode = iw[31:26];
  assign funct  = iw[5:0];

  // Register/immediate fields are decoded by the datapath, not here.
  logic unused_fields;
  assign unused_fields = &{1'b0, iw[25:6]};

  // Main decode: opcode -> strobes and ALU class.
  ctrl_t main_d;
  logic  op_bad;
  always_comb begin
    main_d = '0;
    op_bad = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        main_d.reg_dst   = 1'b1;
        main_d.reg_write = 1'b1;
        main_d.alu_op    = AOP_FUNCT;
      end
      OP_LW: begin
        main_d.reg_write  = 1'b1;
        main_d.alu_src    = 1'b1;
        main_d.mem_read   = 1'b1;
        main_d.mem_to_reg = 1'b1;
        main_d.alu_op     = AOP_ADD;
      end
      OP_SW: begin
        main_d.alu_src   = 1'b1;
        main_d.mem_write = 1'b1;
        main_d.alu_op    = AOP_ADD;
      end
      OP_BEQ: begin
        main_d.branch = 1'b1;
        main_d.alu_op = AOP_SUB;
      end
      default: op_bad = 1'b1;
    endcase
  end

  // ALU decode: ALU class (+ funct for R-type) -> ALU control code.
  logic [3:0] alu_ctrl_d;
  logic       fn_bad;
  always_comb begin
    alu_ctrl_d = AC_AND;
    fn_bad     = 1'b0;
    case (main_d.alu_op)
      AOP_ADD: alu_ctrl_d = AC_ADD;
      AOP_SUB: alu_ctrl_d = AC_SUB;
      AOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl_d = AC_ADD;
          FN_SUB:  alu_ctrl_d = AC_SUB;
          FN_AND:  alu_ctrl_d = AC_AND;
          FN_OR:   alu_ctrl_d = AC_OR;
          FN_SLT:  alu_ctrl_d = AC_SLT;
          default: fn_bad = 1'b1;
        endcase
      end
      default: alu_ctrl_d = AC_AND;
    endcase
  end

  // Combine. An unknown opcode collapses to all-zero plus illegal; an
  // unknown R-type funct keeps ALUOp=10 but kills the register write so
  // the instruction retires as a no-op.
  ctrl_t nxt;
  always_comb begin
    nxt          = main_d;
    nxt.alu_ctrl = alu_ctrl_d;
    if (op_bad) begin
      nxt         = '0;
      nxt.illegal = 1'b1;
    end else if (fn_bad) begin
      nxt.reg_dst   = 1'b0;
      nxt.reg_write = 1'b0;
      nxt.alu_ctrl  = AC_AND;
      nxt.illegal   = 1'b1;
    end
  end

  ctrl_t q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= nxt;
  end

  assign ALUCtrl  = q.alu_ctrl;
  assign ALUOp    = q.alu_op;
  assign regDst   = q.reg_dst;
  assign regWrite = q.reg_write;
  assign ALUSrc   = q.alu_src;
  assign memWrite = q.mem_write;
  assign memRead  = q.mem_read;
  assign memToReg = q.mem_to_reg;
  assign branch   = q.branch;
  assign illegal  = q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, reset / latency
// sequences, and random instructions against a lookup-table model.
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] iw;
  logic [3:0]  ALUCtrl;
  logic [1:0]  ALUOp;
  logic        regDst, regWrite, ALUSrc, memWrite, memRead, memToReg, branch, illegal;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .iw(iw),
    .ALUCtrl(ALUCtrl), .ALUOp(ALUOp), .regDst(regDst), .regWrite(regWrite),
    .ALUSrc(ALUSrc), .memWrite(memWrite), .memRead(memRead),
    .memToReg(memToReg), .branch(branch), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ALUCtrl, ALUOp, regDst, regWrite, ALUSrc, memWrite, memRead, memToReg, branch, illegal}
  logic [13:0] got;
  assign got = {ALUCtrl, ALUOp, regDst, regWrite, ALUSrc, memWrite, memRead,
                memToReg, branch, illegal};

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [13:0] pk(input logic [3:0] ac, input logic [1:0] op,
                                     input logic [7:0] s);
    return {ac, op, s};
  endfunction

  task automatic check(input string name, input logic [13:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // Present w well before the edge, then sample just after the edge.
  task automatic step(input logic [31:0] w);
    @(negedge clk);
    iw = w;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // main_tbl[opcode] = {regDst, regWrite, ALUSrc, memWrite, memRead, memToReg, branch, ALUOp}
  logic [8:0] main_tbl [int];
  logic [3:0] fn_tbl   [int];

  function automatic logic [13:0] model(input logic [31:0] w);
    int op = int'(w[31:26]);
    int fn = int'(w[5:0]);
    logic [8:0] e;
    logic [3:0] ac;
    if (!main_tbl.exists(op)) return 14'b1;           // only illegal set
    e = main_tbl[op];
    if (e[1:0] == 2'b10) begin
      if (!fn_tbl.exists(fn)) return {4'b0000, 2'b10, 7'b0, 1'b1};
      ac = fn_tbl[fn];
    end else begin
      ac = (e[1:0] == 2'b00) ? 4'b0010 : 4'b0110;
    end
    return {ac, e[1:0], e[8:2], 1'b0};
  endfunction

  typedef struct {
    logic [31:0] w;
    logic [13:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[$];

  localparam logic [13:0] E_ILL = 14'b1;
  localparam logic [13:0] E_LW  = {4'b0010, 2'b00, 8'b0_1_1_0_1_1_0_0};

  initial begin
    main_tbl[6'b000000] = {7'b1_1_0_0_0_0_0, 2'b10};
    main_tbl[6'b100011] = {7'b0_1_1_0_1_1_0, 2'b00};
    main_tbl[6'b101011] = {7'b0_0_1_1_0_0_0, 2'b00};
    main_tbl[6'b000100] = {7'b0_0_0_0_0_0_1, 2'b01};
    fn_tbl[6'b100000] = 4'b0010;
    fn_tbl[6'b100010] = 4'b0110;
    fn_tbl[6'b100100] = 4'b0000;
    fn_tbl[6'b100101] = 4'b0001;
    fn_tbl[6'b101010] = 4'b0111;

    tbl.push_back('{32'h03FFFFE0, pk(4'b0010, 2'b10, 8'b1_1_0_0_0_0_0_0), "r_add"});
    tbl.push_back('{32'h03FFFFE2, pk(4'b0110, 2'b10, 8'b1_1_0_0_0_0_0_0), "r_sub"});
    tbl.push_back('{32'h03FFFFE4, pk(4'b0000, 2'b10, 8'b1_1_0_0_0_0_0_0), "r_and"});
    tbl.push_back('{32'h03FFFFE5, pk(4'b0001, 2'b10, 8'b1_1_0_0_0_0_0_0), "r_or"});
    tbl.push_back('{32'h03FFFFEA, pk(4'b0111, 2'b10, 8'b1_1_0_0_0_0_0_0), "r_slt"});
    tbl.push_back('{32'h8FFFFFEA, E_LW, "lw_ones"});
    tbl.push_back('{32'h8C000000, E_LW, "lw_zeros"});
    tbl.push_back('{32'hAFFFFFEA, pk(4'b0010, 2'b00, 8'b0_0_1_1_0_0_0_0), "sw"});
    tbl.push_back('{32'h13FFFFEA, pk(4'b0110, 2'b01, 8'b0_0_0_0_0_0_1_0), "beq"});
    tbl.push_back('{32'h0BFFFFEA, E_ILL, "ill_op_000010"});
    tbl.push_back('{32'h1BFFFFEA, E_ILL, "ill_op_000110"});
    tbl.push_back('{32'h8BFFFFEA, E_ILL, "ill_op_100010"});
    tbl.push_back('{32'h03FFFFFF, pk(4'b0000, 2'b10, 8'b0_0_0_0_0_0_0_1), "ill_funct"});
    tbl.push_back('{32'h00000020, pk(4'b0010, 2'b10, 8'b1_1_0_0_0_0_0_0), "add_clears_ill"});
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    iw    = 32'h8FFFFFEA;
    #1;
    check("reset_state", 14'b0);
    @(posedge clk); #1;
    check("reset_held_over_edge", 14'b0);

    // Release mid-cycle; first edge captures lw.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_decode_lw", E_LW);

    // No combinational path: change iw between edges.
    iw = 32'h13FFFFEA;
    #2;
    check("no_comb_path", E_LW);

    // Asynchronous reset in the middle of a cycle.
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_cycle", 14'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("decode_after_reset", pk(4'b0110, 2'b01, 8'b0_0_0_0_0_0_1_0));

    // Directed table, back to back.
    foreach (tbl[i]) begin
      step(tbl[i].w);
      check(tbl[i].name, tbl[i].exp);
    end

    // Random instructions, biased toward the supported opcodes.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] w;
      logic [5:0]  ops[5];
      logic [5:0]  fns[6];
      ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
      w = $urandom;
      if ($urandom_range(3) != 0) w[31:26] = ops[$urandom_range(4)];
      if ($urandom_range(3) != 0) w[5:0]   = fns[$urandom_range(5)];
      step(w);
      check($sformatf("rand_%0d_iw_%h", k, w), model(w));
      check_bit("excl_mem", memRead & memWrite, 1'b0);
      check_bit("excl_branch", branch & (regWrite | memRead | memWrite), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

endmodule
